text_screen_ctrl: RTL and testbench
===================================

# text_screen_ctrl

Text-mode scan controller for the debug screen. It holds an 80x30 character buffer and walks it in step with the VGA timing generator. For each pixel it drives the character code and the in-glyph pixel coordinates to the glyph ROM (`symbol_mem`), then turns the returned `bg_fg` bit into RGB with aligned syncs. The buffer has a single port, shared between display fetch (highest priority), a buffer-clear engine, and a host write port.

## Interface
- `COLS`, 80: text columns; glyph width fixed at 8 px.
- `ROWS`, 30: text rows; glyph height fixed at 16 px.
- `FG_COLOR`, 12'hFFF: RGB444 foreground.
- `BG_COLOR`, 12'h000: RGB444 background.
- `clk`  in  1  clock; one pixel per clock.
- `rst`  in  1  synchronous, active-high reset.
- `x`, `y`  in  10 each  pixel position from timing generator.
- `de_i`, `hs_i`, `vs_i`  in  1 each  display enable, hsync, vsync.
- `wr_valid`  in  1  host write request.
- `wr_addr`  in  12  linear cell address, row*COLS+col.
- `wr_data`  in  8  ASCII code.
- `wr_ready`  out  1  host write accepted this cycle when high with `wr_valid`.
- `clr_req`  in  1  single-cycle request to fill the buffer with 0x20.
- `busy`  out  1  clear in progress.
- `ascii`  out  8  to glyph ROM.
- `pix_x`  out  3  to glyph ROM.
- `pix_y`  out  4  to glyph ROM.
- `bg_fg`  in  1  from glyph ROM; registered there, valid one clock after `ascii`/`pix_*`.
- `rgb`  out  12  pixel colour.
- `de_o`, `hs_o`, `vs_o`  out  1 each  aligned with `rgb`.

## Operation
- **Display slot.** A cycle is a display slot when `de_i && x[2:0]==0`. In a display slot the controller reads buffer address `(y>>4)*COLS + (x>>3)`.
- **Free slots.** Every other cycle is free, and the buffer port goes to the clear engine or the host, in that order.
- **Buffer.** 4096x8 single-port RAM with a registered read. Cell addresses ≥ COLS*ROWS are never displayed.
- **Character hold.** `disp_q` marks that the previous cycle was a display slot.
  - `ascii = disp_q ? ram_q : char_hold`.
  - `char_hold <= ascii` every cycle.
  - The character therefore stays stable across the 8 pixels of a cell, even while the host is writing.
- **Glyph coordinates.** `pix_x`/`pix_y` are `x[2:0]`/`y[3:0]` delayed one clock.
- **Blanking outside text area.** If `x >= COLS*8` or `y >= ROWS*16`, the cell is forced blank and `rgb = BG_COLOR`.
- **FSM.** Two states, CLEAR and IDLE.
  - CLEAR: `busy=1`, `wr_ready=0`. Each free slot writes 0x20 at `clr_cnt`, then increments it. When `clr_cnt == COLS*ROWS-1` is written, go to IDLE.
  - IDLE: `busy=0`. `clr_req` sets `clr_cnt=0` and moves to CLEAR.
  - `clr_req` while in CLEAR is ignored.
- **Host port.**
  - `wr_ready = (state==IDLE) && free slot && !clr_req`. This is combinational from the current inputs.
  - On transfer, if `wr_addr < COLS*ROWS` the RAM is written; otherwise the write is accepted and discarded.
- **Output colour.** `rgb = de ? (in-area && bg_fg ? FG_COLOR : BG_COLOR) : 12'h000`.

## Timing
- Total latency is 3 clocks from `x`/`y`/`de_i`/`hs_i`/`vs_i` to `rgb`/`de_o`/`hs_o`/`vs_o`:
  - t: inputs sampled, RAM read issued.
  - t+1: `ascii`/`pix_*` valid.
  - t+2: `bg_fg` valid.
  - t+3: outputs registered.
- Sync and `de` pass through a 3-deep shift register.
- **Reset.**
  - Reset values: `rgb=0`, `de_o`/`hs_o`/`vs_o` = 0, `ascii=0`, `pix_x=0`, `pix_y=0`, `char_hold=0`, `disp_q=0`, `clr_cnt=0`.
  - On release the state is CLEAR, so `busy=1` at the first cycle after reset.
  - Reset during a clear restarts the clear at 0.
  - A host write counts as performed only if it was accepted before the reset cycle.
- **Clear duration.** With `de_i` low throughout, a clear takes exactly COLS*ROWS = 2400 cycles. Each display slot extends it by one cycle.
- **Host write visibility.** A write becomes visible at the next display fetch of that cell. The cell currently being displayed keeps its old code until its next fetch.

## Structure
- **Package `dsc_pkg`.**
  - Constants: `GLYPH_W=8`, `GLYPH_H=16`, `SPACE=8'h20`, `TBUF_AW=12`.
  - `typedef enum logic {CLEAR, IDLE} tsc_state_t`.
  - RGB444 colour typedef.
- **Sub-module `text_ram`.** Single-port 4096x8 RAM with write enable and registered read. Not reset.
- `symbol_mem` stays a sibling instance wired at the top level.

## Test plan
- **Reset and clear.** Assert `rst` for 2 cycles with `de_i=0` → `busy` is high for exactly 2400 cycles. Afterwards every in-area cell fetches `ascii=0x20`.
- **Single write and display.** Write 0x41 to address 81 → for pixels x=8..15, y=16..31:
  - `ascii=0x41` one clock after the pixel.
  - `pix_x` runs 0..7 and `pix_y` runs 0..15.
  - With `bg_fg` driven 1, `rgb=12'hFFF` three clocks after the pixel.
- **Arbitration.** Hold `wr_valid` while `de_i=1` and x=16 → `wr_ready=0`. At x=17 → `wr_ready=1`. `ascii` for the cell at x=16..23 is unchanged until the next fetch of that cell.
- **Out-of-range write.** Write to `wr_addr=2400` → accepted in one cycle. A full-screen scan shows no change.
- **Alignment and blanking.** Toggle `hs_i`/`vs_i`/`de_i` → `hs_o`/`vs_o`/`de_o` follow 3 clocks later. `rgb=0` whenever `de_o=0`. `rgb=BG_COLOR` for y=480 with `de_i=1`.
- **Clear requests.** `clr_req` pulsed mid-clear → ignored, and `busy` falls at the original time. `clr_req` while IDLE with `wr_valid` in the same cycle → `wr_ready=0`, and `busy` rises the next cycle.

Source files
------------

// File: rtl/dsc_pkg.sv
// Shared constants and types for the debug-screen text controller.
//   GLYPH_W/GLYPH_H : glyph cell size in pixels
//   SPACE           : code written by the buffer-clear engine
//   TBUF_AW         : text buffer address width (4096 cells)
//   tsc_state_t     : clear-engine / host-port arbitration state
//   rgb444_t        : 12-bit RGB444 colour
package dsc_pkg;

  localparam int unsigned GLYPH_W = 8;
  localparam int unsigned GLYPH_H = 16;
  localparam logic [7:0]  SPACE   = 8'h20;
  localparam int unsigned TBUF_AW = 12;

  typedef enum logic {
    CLEAR,
    IDLE
  } tsc_state_t;

  typedef logic [11:0] rgb444_t;

endpackage

// File: rtl/text_ram.sv
// Single-port text buffer RAM with write enable and registered read.
// Contents are not reset; the clear engine initialises them.
//   clk_i   : clock
//   we_i    : write enable
//   addr_i  : cell address (shared by read and write)
//   wdata_i : write data
//   rdata_o : read data, valid one clock after addr_i
module text_ram
  import dsc_pkg::*;
#(
  parameter int unsigned AW = TBUF_AW,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/text_screen_ctrl.sv
// Text-mode scan controller. Walks an 80x30 character buffer in step with the
// VGA timing generator, feeds the glyph ROM and turns its pixel bit into RGB.
//   clk, rst            : pixel clock, synchronous active-high reset
//   x, y, de_i/hs_i/vs_i: pixel position and timing from the timing generator
//   wr_valid/addr/data  : host write port, wr_ready accepts in the same cycle
//   clr_req, busy       : start buffer fill with spaces, fill in progress
//   ascii, pix_x, pix_y : glyph ROM request; bg_fg returns one clock later
//   rgb, de_o/hs_o/vs_o : pixel output, 3 clocks after the inputs
module text_screen_ctrl
  import dsc_pkg::*;
#(
  parameter int unsigned COLS     = 80,
  parameter int unsigned ROWS     = 30,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               de_i,
  input  logic               hs_i,
  input  logic               vs_i,
  input  logic               wr_valid,
  input  logic [TBUF_AW-1:0] wr_addr,
  input  logic [7:0]         wr_data,
  output logic               wr_ready,
  input  logic               clr_req,
  output logic               busy,
  output logic [7:0]         ascii,
  output logic [2:0]         pix_x,
  output logic [3:0]         pix_y,
  input  logic               bg_fg,
  output logic [11:0]        rgb,
  output logic               de_o,
  output logic               hs_o,
  output logic               vs_o
);

  localparam logic [9:0]         XMAX_PX   = 10'(COLS * GLYPH_W);
  localparam logic [9:0]         YMAX_PX   = 10'(ROWS * GLYPH_H);
  localparam logic [TBUF_AW-1:0] NCELLS    = TBUF_AW'(COLS * ROWS);
  localparam logic [TBUF_AW-1:0] LAST_CELL = TBUF_AW'(COLS * ROWS - 1);

  tsc_state_t         state_q, state_d;
  logic [TBUF_AW-1:0] clr_cnt_q, clr_cnt_d;
  logic               disp_q;
  logic [7:0]         char_hold_q;
  logic [2:0]         pix_x_q;
  logic [3:0]         pix_y_q;
  logic [1:0]         in_area_q;
  logic [2:0]         de_sr_q, hs_sr_q, vs_sr_q;
  rgb444_t            rgb_q, rgb_d;

  logic               disp_slot;
  logic               in_area;
  logic [TBUF_AW-1:0] disp_addr;
  logic               ram_we;
  logic [TBUF_AW-1:0] ram_addr;
  logic [7:0]         ram_wdata;
  logic [7:0]         ram_rdata;

  always_comb begin
    disp_slot = de_i && (x[2:0] == 3'd0);
    in_area   = (x < XMAX_PX) && (y < YMAX_PX);
    // Out-of-area pixels may alias other cells; the result is blanked later.
    disp_addr = TBUF_AW'(32'(y[9:4]) * COLS + 32'(x[9:3]));
  end

  // Buffer port arbitration: display fetch, then clear engine, then host.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ram_we    = 1'b0;
    ram_addr  = disp_addr;
    ram_wdata = SPACE;
    busy      = 1'b0;
    wr_ready  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        busy = 1'b1;
        if (!disp_slot) begin
          ram_we    = 1'b1;
          ram_addr  = clr_cnt_q;
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_CELL) begin
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (!disp_slot) begin
          wr_ready = 1'b1;
          if (wr_valid) begin
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
            // Writes past the visible area are accepted but dropped.
            ram_we    = (wr_addr < NCELLS);
          end
        end
      end
    endcase
  end

  text_ram #(
    .AW(TBUF_AW),
    .DW(8)
  ) u_text_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  // RAM data is only meaningful right after a fetch; otherwise hold the code so
  // a cell keeps its character for all 8 pixels even if the host rewrites it.
  always_comb begin
    ascii = disp_q ? ram_rdata : char_hold_q;
  end

  // bg_fg lines up with de_sr_q[1] / in_area_q[1].
  always_comb begin
    if (!de_sr_q[1]) begin
      rgb_d = 12'h000;
    end else if (in_area_q[1] && bg_fg) begin
      rgb_d = FG_COLOR;
    end else begin
      rgb_d = BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      disp_q      <= 1'b0;
      char_hold_q <= 8'h00;
      pix_x_q     <= 3'd0;
      pix_y_q     <= 4'd0;
      in_area_q   <= 2'b00;
      de_sr_q     <= 3'b000;
      hs_sr_q     <= 3'b000;
      vs_sr_q     <= 3'b000;
      rgb_q       <= 12'h000;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      disp_q      <= disp_slot;
      char_hold_q <= ascii;
      pix_x_q     <= x[2:0];
      pix_y_q     <= y[3:0];
      in_area_q   <= {in_area_q[0], in_area};
      de_sr_q     <= {de_sr_q[1:0], de_i};
      hs_sr_q     <= {hs_sr_q[1:0], hs_i};
      vs_sr_q     <= {vs_sr_q[1:0], vs_i};
      rgb_q       <= rgb_d;
    end
  end

  assign pix_x = pix_x_q;
  assign pix_y = pix_y_q;
  assign rgb   = rgb_q;
  assign de_o  = de_sr_q[2];
  assign hs_o  = hs_sr_q[2];
  assign vs_o  = vs_sr_q[2];

endmodule

// File: tb/tb_text_screen_ctrl.sv
// Bench for text_screen_ctrl: a shadow copy of the text buffer predicts the
// glyph request and pixel output for every driven pixel; predictions are queued
// and compared when the DUT is due to produce them.
module tb_text_screen_ctrl;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h048;
  localparam int NCELLS = 2400;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x, y;
  logic        de_i, hs_i, vs_i;
  logic        wr_valid;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        clr_req;
  logic        busy;
  logic [7:0]  ascii;
  logic [2:0]  pix_x;
  logic [3:0]  pix_y;
  logic        bg_fg;
  logic [11:0] rgb;
  logic        de_o, hs_o, vs_o;

  always #5 clk = ~clk;

  text_screen_ctrl #(
    .COLS    (80),
    .ROWS    (30),
    .FG_COLOR(FG),
    .BG_COLOR(BG)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .y       (y),
    .de_i    (de_i),
    .hs_i    (hs_i),
    .vs_i    (vs_i),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .clr_req (clr_req),
    .busy    (busy),
    .ascii   (ascii),
    .pix_x   (pix_x),
    .pix_y   (pix_y),
    .bg_fg   (bg_fg),
    .rgb     (rgb),
    .de_o    (de_o),
    .hs_o    (hs_o),
    .vs_o    (vs_o)
  );

  // Glyph ROM stand-in: a pixel is lit when the code is odd (0x41 lit, 0x20 dark).
  always_ff @(posedge clk) bg_fg <= ascii[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int         due;
    logic [7:0] asc;
    bit         asc_care;
    logic [2:0] px;
    logic [3:0] py;
  } a_exp_t;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    bit          rgb_care;
    logic        de, hs, vs;
  } o_exp_t;

  a_exp_t qa[$];
  o_exp_t qo[$];

  logic [7:0] shadow [NCELLS];
  logic [7:0] m_hold;
  bit         m_known;

  always @(negedge clk) begin : mon
    a_exp_t ea;
    o_exp_t eo;
    while (qa.size() > 0 && qa[0].due <= cyc) begin
      ea = qa.pop_front();
      if (ea.due != cyc) chk("sb_late_a", cyc, ea.due);
      if (ea.asc_care) chk("ascii", 32'(ascii), 32'(ea.asc));
      chk("pix_x", 32'(pix_x), 32'(ea.px));
      chk("pix_y", 32'(pix_y), 32'(ea.py));
    end
    while (qo.size() > 0 && qo[0].due <= cyc) begin
      eo = qo.pop_front();
      if (eo.due != cyc) chk("sb_late_o", cyc, eo.due);
      if (eo.rgb_care) chk("rgb", 32'(rgb), 32'(eo.rgb));
      chk("de_o", 32'(de_o), 32'(eo.de));
      chk("hs_o", 32'(hs_o), 32'(eo.hs));
      chk("vs_o", 32'(vs_o), 32'(eo.vs));
    end
  end

  // Drive one pixel cycle and queue what the DUT must produce for it.
  task automatic drive(input bit r, input int xx, input int yy, input bit de, input bit hs,
                       input bit vs, input bit wv = 1'b0, input int wa = 0,
                       input logic [7:0] wd = 8'h00, input bit cr = 1'b0);
    bit     slot, in_a;
    int     addr;
    a_exp_t ea;
    o_exp_t eo;
    @(posedge clk);
    #1;
    rst = r; x = 10'(xx); y = 10'(yy); de_i = de; hs_i = hs; vs_i = vs;
    wr_valid = wv; wr_addr = 12'(wa); wr_data = wd; clr_req = cr;
    if (r) begin
      qa.delete();
      qo.delete();
      m_hold  = 8'h00;
      m_known = 1'b1;
      for (int i = 0; i < NCELLS; i++) shadow[i] = 8'h20;
      return;
    end
    slot = de && (xx % 8 == 0);
    in_a = (xx < 640) && (yy < 480);
    addr = (yy / 16) * 80 + xx / 8;
    if (slot) begin
      if (in_a) begin
        m_hold  = shadow[addr];
        m_known = 1'b1;
      end else begin
        m_known = 1'b0;
      end
    end
    ea.due = cyc + 1; ea.asc = m_hold; ea.asc_care = m_known;
    ea.px = 3'(xx % 8); ea.py = 4'(yy % 16);
    qa.push_back(ea);
    eo.due = cyc + 3; eo.de = de; eo.hs = hs; eo.vs = vs; eo.rgb_care = 1'b1;
    if (!de) eo.rgb = 12'h000;
    else if (!in_a) eo.rgb = BG;
    else begin
      eo.rgb = m_hold[0] ? FG : BG;
      eo.rgb_care = m_known;
    end
    qo.push_back(eo);
    if (cr) for (int i = 0; i < NCELLS; i++) shadow[i] = 8'h20;
    #1;
    if (wv && wr_ready && wa < NCELLS) shadow[wa] = wd;
  endtask

  task automatic rst_check();
    @(negedge clk);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_de_o", 32'(de_o), 0);
    chk("rst_hs_o", 32'(hs_o), 0);
    chk("rst_vs_o", 32'(vs_o), 0);
    chk("rst_ascii", 32'(ascii), 0);
    chk("rst_pix_x", 32'(pix_x), 0);
    chk("rst_pix_y", 32'(pix_y), 0);
    chk("rst_busy", 32'(busy), 1);
  endtask

  // Count cycles with busy high; optional display slots and a stray clr_req.
  task automatic busy_run(input string tag, input int exp_len, input int slot_at = -1,
                          input int nslots = 0, input int req_at = -1);
    int n = 0;
    bit done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      if (slot_at >= 0 && i >= slot_at && i < slot_at + nslots)
        drive(0, (i - slot_at) * 8, 320, 1, 0, 0);
      else
        drive(0, 0, 0, 0, 0, 0, (i == 7), 81, 8'h55, (i == req_at));
      if (i == 7) chk("wr_ready_busy", 32'(wr_ready), 0);
      @(negedge clk);
      if (busy) n++;
      else done = 1'b1;
    end
    chk(tag, n, exp_len);
  endtask

  task automatic fetch_scan();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++)
        drive(0, c * 8, r * 16, 1, 0, 0);
  endtask

  initial begin
    rst = 1'b1; x = '0; y = '0; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;

    // Reset and the power-on clear
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    rst_check();
    busy_run("clr_len_rst", 2400);
    fetch_scan();

    // Single write, then pixels of cell (row 1, col 1) and neighbours
    drive(0, 0, 0, 0, 0, 0, 1, 81, 8'h41);
    chk("wr_ready_idle", 32'(wr_ready), 1);
    for (int yy = 16; yy < 32; yy++)
      for (int xx = 0; xx < 32; xx++)
        drive(0, xx, yy, 1, 0, 0);

    // Arbitration against display fetch; displayed cell keeps old code
    drive(0, 16, 16, 1, 0, 0, 1, 82, 8'h41);
    chk("wr_ready_slot", 32'(wr_ready), 0);
    drive(0, 17, 16, 1, 0, 0, 1, 82, 8'h41);
    chk("wr_ready_free", 32'(wr_ready), 1);
    for (int xx = 18; xx < 24; xx++) drive(0, xx, 16, 1, 0, 0);
    for (int xx = 16; xx < 24; xx++) drive(0, xx, 17, 1, 0, 0);

    // Out-of-range write is accepted and dropped
    drive(0, 0, 0, 0, 0, 0, 1, 2400, 8'h41);
    chk("wr_ready_oor", 32'(wr_ready), 1);
    fetch_scan();

    // Blanking: below the text area, and right of it aliasing a lit cell
    for (int xx = 8; xx < 16; xx++) drive(0, xx, 480, 1, 0, 0);
    for (int xx = 648; xx < 656; xx++) drive(0, xx, 0, 1, 0, 0);

    // Sync/de alignment with random timing
    for (int i = 0; i < 300; i++)
      drive(0, int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));

    // Clear request while idle, host write in the same cycle loses
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 81, 8'h55, 1);
    chk("wr_ready_clr_req", 32'(wr_ready), 0);
    busy_run("clr_len_req", 2405, 500, 5, 1000);
    for (int c = 0; c < 80; c++) drive(0, c * 8, 16, 1, 0, 0);

    // Reset in the middle of a clear restarts it from the beginning
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 300; i++) drive(0, 0, 0, 0, 0, 0);
    for (int xx = 8; xx < 12; xx++) drive(0, xx, 17, 1, 1, 1);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    rst_check();
    busy_run("clr_len_rst2", 2400);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
